wb_port_arb: RTL and testbench

WB_PORT_ARB -- requirements
Module: wb_port_arb

---
 rtl/wb_port_arb_pkg.sv | 20 ++
 rtl/wb_rr_pick.sv | 24 ++
 rtl/wb_port_arb.sv | 74 +++++++
 tb/tb_wb_port_arb.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arb_pkg.sv
// Shared datapath definitions for the register-file write-port arbiter:
// default widths, requester ids and the pointer reset value.
package wb_port_arb_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_e;

  // Pointer starts on the load path so the ALU wins the first tie.
  localparam req_id_e PTR_RST = REQ_MEM;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Two-way round-robin grant selection: a lone requester always wins,
// a tie goes to the requester that did not win last.
module wb_rr_pick
  import wb_port_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  req_id_e    ptr,
  input  logic       hold,
  output logic [1:0] grant
);

  always_comb begin
    // NOTE: default assignment first so no path through the block leaves grant unassigned (no latch).
    grant = 2'b00;
    if (!hold) begin
      if (&valid) begin
        grant = (ptr == REQ_MEM) ? 2'b01 : 2'b10;
      end else begin
        grant = valid;
      end
    end
  end

endmodule

// File: rtl/wb_port_arb.sv
// Arbitrates the ALU and load-path writes onto the single register-file
// write port, registering the winner's address/data for one cycle.
module wb_port_arb
  import wb_port_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic              rf_sel,
  output logic [7:0]        conflict_cnt
);

  logic [1:0]        grant;
  req_id_e           ptr_q;
  req_id_e           gid;
  logic              xfer;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  // Reset is folded into hold so ready is already low during reset.
  wb_rr_pick u_pick (
    .valid ({req1_valid, req0_valid}),
    .ptr   (ptr_q),
    .hold  (hold | rst),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign xfer       = |grant;
  assign gid        = grant[1] ? REQ_MEM : REQ_ALU;
  assign win_addr   = grant[1] ? req1_addr : req0_addr;
  assign win_data   = grant[1] ? req1_data : req0_data;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
    if (rst) begin
      rf_we        <= 1'b0;
      rf_wa        <= '0;
      rf_wd        <= '0;
      rf_sel       <= 1'b0;
      ptr_q        <= PTR_RST;
      conflict_cnt <= 8'd0;
    end else begin
      if (req0_valid && req1_valid) begin
        conflict_cnt <= sat_inc8(conflict_cnt);
      end
      rf_we <= 1'b0;
      if (xfer) begin
        // Register 0 is hardwired: the write is consumed but never enabled.
        rf_we  <= (win_addr != '0);
        rf_wa  <= win_addr;
        rf_wd  <= win_data;
        rf_sel <= gid;
        ptr_q  <= gid;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arb.sv
// Self-checking bench for wb_port_arb: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_wb_port_arb;
  import wb_port_arb_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          hold;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_data, req1_data;
  logic          rf_we;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;
  logic          rf_sel;
  logic [7:0]    conflict_cnt;

  int n_err = 0;
  int n_chk = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  wb_port_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .hold         (hold),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_addr    (req0_addr),
    .req0_data    (req0_data),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_addr    (req1_addr),
    .req1_data    (req1_data),
    .rf_we        (rf_we),
    .rf_wa        (rf_wa),
    .rf_wd        (rf_wd),
    .rf_sel       (rf_sel),
    .conflict_cnt (conflict_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic h,
                       input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    rst = r; hold = h;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  int            m_ptr = 1;
  logic          m_we  = 1'b0;
  logic [AW-1:0] m_wa  = '0;
  logic [DW-1:0] m_wd  = '0;
  logic          m_sel = 1'b0;
  int            m_cnt = 0;

  // Which requester transfers this cycle under the arbitration rules, -1 if none.
  function automatic int winner();
    if (rst || hold) return -1;
    if (req0_valid && req1_valid) return 1 - m_ptr;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ptr <= 1; m_we <= 1'b0; m_wa <= '0; m_wd <= '0; m_sel <= 1'b0; m_cnt <= 0;
    end else begin
      if (req0_valid && req1_valid && m_cnt < 255) m_cnt <= m_cnt + 1;
      if (winner() == 0) begin
        m_we <= (req0_addr != '0); m_wa <= req0_addr; m_wd <= req0_data;
        m_sel <= 1'b0; m_ptr <= 0;
      end else if (winner() == 1) begin
        m_we <= (req1_addr != '0); m_wa <= req1_addr; m_wd <= req1_data;
        m_sel <= 1'b1; m_ptr <= 1;
      end else begin
        m_we <= 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int w0 = 0;
  int w1 = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("req0_ready", 32'(req0_ready), 32'(winner() == 0));
      check("req1_ready", 32'(req1_ready), 32'(winner() == 1));
      check("rf_we", 32'(rf_we), 32'(m_we));
      check("rf_wa", 32'(rf_wa), 32'(m_wa));
      check("rf_wd", rf_wd, m_wd);
      check("rf_sel", 32'(rf_sel), 32'(m_sel));
      check("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
      // A continuously eligible requester may lose at most one cycle in a row.
      check("wait0_bound", 32'(!rst && !hold && req0_valid && !req0_ready && w0 >= 1), 0);
      check("wait1_bound", 32'(!rst && !hold && req1_valid && !req1_ready && w1 >= 1), 0);
      w0 <= (!rst && !hold && req0_valid && !req0_ready) ? w0 + 1 : 0;
      w1 <= (!rst && !hold && req1_valid && !req1_ready) ? w1 + 1 : 0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic          r, h, v0, v1;
    logic [AW-1:0] a0, a1;

    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    repeat (2) tick();
    chk_en = 1'b1;
    check("rst_we", 32'(rf_we), 0);
    check("rst_wa", 32'(rf_wa), 0);
    check("rst_wd", rf_wd, 0);
    check("rst_sel", 32'(rf_sel), 0);
    check("rst_cnt", 32'(conflict_cnt), 0);

    // Single ALU write.
    drive(1'b0, 1'b0, 1'b1, 5'd5, 32'h1234, 1'b0, '0, '0);
    @(negedge clk);
    check("t1_ready0", 32'(req0_ready), 1);
    check("t1_ready1", 32'(req1_ready), 0);
    tick();
    check("t1_we", 32'(rf_we), 1);
    check("t1_wa", 32'(rf_wa), 5);
    check("t1_wd", rf_wd, 32'h1234);
    check("t1_sel", 32'(rf_sel), 0);

    // First tie after reset alternates starting with requester 0.
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 5'd3, 32'hA3, 1'b1, 5'd7, 32'hB7);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("tie_ready0", 32'(req0_ready), 32'(i % 2 == 0));
      check("tie_ready1", 32'(req1_ready), 32'(i % 2 == 1));
      tick();
      check("tie_wa", 32'(rf_wa), (i % 2 == 1) ? 7 : 3);
      check("tie_sel", 32'(rf_sel), 32'(i % 2));
      check("tie_we", 32'(rf_we), 1);
    end
    check("tie_cnt", 32'(conflict_cnt), 4);

    // Write to register 0: consumed, no enable.
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF);
    @(negedge clk);
    check("r0_ready1", 32'(req1_ready), 1);
    tick();
    check("r0_we", 32'(rf_we), 0);
    check("r0_wa", 32'(rf_wa), 0);
    check("r0_wd", rf_wd, 32'hFFFF);
    check("r0_sel", 32'(rf_sel), 1);

    // Hold with both valid: no grants, counter still runs.
    drive(1'b0, 1'b1, 1'b1, 5'd9, 32'h99, 1'b1, 5'd12, 32'hCC);
    repeat (3) begin
      @(negedge clk);
      check("hold_ready0", 32'(req0_ready), 0);
      check("hold_ready1", 32'(req1_ready), 0);
      tick();
      check("hold_we", 32'(rf_we), 0);
    end
    check("hold_cnt", 32'(conflict_cnt), 7);
    check("hold_wa", 32'(rf_wa), 0);
    check("hold_wd", rf_wd, 32'hFFFF);
    drive(1'b0, 1'b0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd12, 32'hCC);
    @(negedge clk);
    check("rel_ready0", 32'(req0_ready), 1);
    check("rel_ready1", 32'(req1_ready), 0);
    tick();
    check("rel_we", 32'(rf_we), 1);
    check("rel_wa", 32'(rf_wa), 9);
    check("rel_sel", 32'(rf_sel), 0);
    check("rel_cnt", 32'(conflict_cnt), 8);

    // Randomized traffic, checked by the compare process.
    for (int i = 0; i < 2000; i++) begin
      r  = ($urandom_range(0, 99) < 2);
      h  = ($urandom_range(0, 99) < 20);
      v0 = ($urandom_range(0, 99) < 60);
      v1 = ($urandom_range(0, 99) < 60);
      a0 = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom_range(1, 31));
      a1 = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom_range(1, 31));
      drive(r, h, v0, a0, $urandom(), v1, a1, $urandom());
      tick();
    end

    // Counter saturation, then reset mid-stream.
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66);
    repeat (300) tick();
    check("sat_cnt", 32'(conflict_cnt), 255);
    check("sat_we", 32'(rf_we), 1);
    drive(1'b1, 1'b0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66);
    @(negedge clk);
    check("mrst_ready0", 32'(req0_ready), 0);
    check("mrst_ready1", 32'(req1_ready), 0);
    tick();
    check("mrst_we", 32'(rf_we), 0);
    check("mrst_wa", 32'(rf_wa), 0);
    check("mrst_wd", rf_wd, 0);
    check("mrst_sel", 32'(rf_sel), 0);
    check("mrst_cnt", 32'(conflict_cnt), 0);
    drive(1'b0, 1'b0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66);
    @(negedge clk);
    check("post_ready0", 32'(req0_ready), 1);
    check("post_ready1", 32'(req1_ready), 0);
    tick();
    check("post_wa", 32'(rf_wa), 4);
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
